// File: rtl/shift_normalizer_if.sv
// Request/result bundle for the iterative shift normalizer.
// The requester holds the master side, the normalizer the slave side.
interface shift_normalizer_if #(
  parameter int WIDTH = 32,
  parameter int CNT_W = $clog2(WIDTH) + 1
);
  logic             start_in;
  logic             mode_in;
  logic [WIDTH-1:0] data_in;
  logic             busy_out;
  logic             done_out;
  logic [WIDTH-1:0] norm_out;
  logic [CNT_W-1:0] count_out;
  logic             zero_out;

  modport master (
    output start_in, mode_in, data_in,
    input  busy_out, done_out, norm_out, count_out, zero_out
  );

  modport slave (
    input  start_in, mode_in, data_in,
    output busy_out, done_out, norm_out, count_out, zero_out
  );
endinterface

// File: rtl/shift_normalizer.sv
// Iterative normalizer: shifts the operand one bit per cycle until the MSB (left mode)
// or LSB (right mode) is set, reporting the shift count (CLZ / CTZ).
module shift_normalizer #(
  parameter int WIDTH = 32,
  parameter int CNT_W = $clog2(WIDTH) + 1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  shift_normalizer_if.slave    bus
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t           state_reg,  state_next;
  logic [WIDTH-1:0] shift_reg,  shift_next;
  logic [CNT_W-1:0] cnt_reg,    cnt_next;
  logic             mode_reg,   mode_next;
  logic [WIDTH-1:0] norm_reg,   norm_next;
  logic [CNT_W-1:0] count_reg,  count_next;
  logic             zero_reg,   zero_next;
  logic             target_bit;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= IDLE;
      shift_reg <= '0;
      cnt_reg   <= '0;
      mode_reg  <= 1'b0;
      norm_reg  <= '0;
      count_reg <= '0;
      zero_reg  <= 1'b0;
    end else begin
      state_reg <= state_next;
      shift_reg <= shift_next;
      cnt_reg   <= cnt_next;
      mode_reg  <= mode_next;
      norm_reg  <= norm_next;
      count_reg <= count_next;
      zero_reg  <= zero_next;
    end
  end

  // Only the registered mode steers the shift; mode_in is ignored once accepted.
  assign target_bit = mode_reg ? shift_reg[0] : shift_reg[WIDTH-1];

  always_comb begin
    state_next = state_reg;
    shift_next = shift_reg;
    cnt_next   = cnt_reg;
    mode_next  = mode_reg;
    norm_next  = norm_reg;
    count_next = count_reg;
    zero_next  = zero_reg;

    case (state_reg)
      IDLE: begin
        if (bus.start_in) begin
          shift_next = bus.data_in;
          mode_next  = bus.mode_in;
          cnt_next   = '0;
          if (bus.data_in == '0) begin
            // Zero operand short-circuits straight to DONE with a full-width count.
            zero_next  = 1'b1;
            cnt_next   = CNT_W'(WIDTH);
            norm_next  = '0;
            count_next = CNT_W'(WIDTH);
            state_next = DONE;
          end else begin
            zero_next  = 1'b0;
            state_next = SHIFT;
          end
        end
      end

      SHIFT: begin
        if (target_bit) begin
          norm_next  = shift_reg;
          count_next = cnt_reg;
          state_next = DONE;
        end else begin
          shift_next = mode_reg ? (shift_reg >> 1) : (shift_reg << 1);
          cnt_next   = cnt_reg + CNT_W'(1);
        end
      end

      DONE: begin
        state_next = IDLE;
      end

      default: begin
        state_next = IDLE;
      end
    endcase
  end

  assign bus.busy_out  = (state_reg == SHIFT) || (state_reg == DONE);
  assign bus.done_out  = (state_reg == DONE);
  assign bus.norm_out  = norm_reg;
  assign bus.count_out = count_reg;
  assign bus.zero_out  = zero_reg;

endmodule

// File: doc/shift_normalizer.md
Name: shift_normalizer

Overview:
- Iterative normalizer; it is the inverse of the 1-bit shifter stage.
- The shifter applies a known shift. This block takes a value and finds the shift that normalizes it.
- Left mode moves the operand one bit per cycle until bit WIDTH-1 is set (leading-zero count).
- Right mode moves it until bit 0 is set (trailing-zero count).
- Used by the FPU for mantissa normalization after subtraction, and by the ALU for CLZ/CTZ-style operations.

Parameters:
- WIDTH, 32, operand width in bits (power of two, >= 4).
- CNT_W, $clog2(WIDTH)+1, width of the shift count; must hold values 0..WIDTH.

Ports:
- clk  input  1  single clock; all state updates on its rising edge.
- rst_n  input  1  asynchronous active-low reset.
- start_in  input  1  request pulse; sampled only in IDLE.
- mode_in  input  1  0 = normalize left (shift left logical), 1 = normalize right (shift right logical); sampled with start_in.
- data_in  input  WIDTH  operand; sampled with start_in.
- busy_out  output  1  high while state is SHIFT or DONE.
- done_out  output  1  one-cycle pulse; results are valid from this cycle onward.
- norm_out  output  WIDTH  normalized operand.
- count_out  output  CNT_W  number of 1-bit shifts applied.
- zero_out  output  1  operand was zero.

Behaviour:
- Reset (async assert, any state):
  - state = IDLE.
  - norm_out = 0, count_out = 0, zero_out = 0.
  - busy_out = 0, done_out = 0.
  - Internal shift register, count and mode register all cleared.
  - An operation in progress is aborted with no done_out.
- States:
  - IDLE: busy_out = 0.
    - On start_in = 1, capture data_in into the shift register and mode_in into the mode register, and clear the count.
    - If data_in = 0: set zero_out = 1 and count = WIDTH, and go to DONE.
    - Otherwise: clear zero_out and go to SHIFT.
  - SHIFT: each cycle, test the target bit (bit WIDTH-1 for left mode, bit 0 for right mode).
    - Target bit set: go to DONE; register and count unchanged.
    - Target bit clear: shift by 1, zero-filling; right mode is logical, never arithmetic. Increment the count.
  - DONE: done_out = 1 for exactly this cycle, then go to IDLE unconditionally.
- Result outputs:
  - norm_out, count_out and zero_out are driven from registers.
  - They update on entry to DONE and hold until the next accepted start.
  - They are not disturbed while SHIFT runs.
- Latency, with the accepting edge as E0:
  - Nonzero operand with k leading zeros (left) or k trailing zeros (right): done_out is high in the cycle after edge E(k+1).
  - k = 0 therefore gives done_out after E1.
  - Maximum for a nonzero operand: k = WIDTH-1, done after E(WIDTH).
  - Zero operand: done_out is high in the cycle after E0.
- start_in while busy_out = 1 (SHIFT or DONE) is ignored; no queueing.
- Back-to-back operation: start_in in the cycle after done_out is accepted, since the state is IDLE again.
- Invariants:
  - The count never exceeds WIDTH-1 on the nonzero path; no wrap is possible.
  - The count equals WIDTH only together with zero_out = 1.
- Mode and data are taken only from the registers after acceptance; changes on mode_in or data_in during SHIFT have no effect.

Test Plan:
- Left, data_in = 0x0000_0001 -> done 32 cycles after acceptance; norm_out = 0x8000_0000, count_out = 31, zero_out = 0.
- Left, data_in = 0x8000_0000 -> done after E1; norm_out = 0x8000_0000, count_out = 0.
  - Then immediately right mode, data_in = 0x0000_0100 -> norm_out = 0x0000_0001, count_out = 8.
- data_in = 0, either mode -> done in the cycle after E0; zero_out = 1, count_out = 32, norm_out = 0.
- Right, data_in = 0x8000_0000 -> norm_out = 0x0000_0001, count_out = 31; the top bit must not be sign-filled.
- Left, data_in = 0x0001_0000 with a second start_in (data 0xFFFF_FFFF) pulsed mid-SHIFT -> second request ignored; result 0x8000_0000, count_out = 15; one done_out pulse only.
- Start left on 0x0000_0001, assert rst_n low at cycle 10 -> all outputs 0 immediately, no done_out.
  - After release, a new request on 0x4000_0000 gives count_out = 1.
